// File: rtl/pea_pkg.sv
// Shared definitions for the polynomial evaluation accelerator result path:
// status codes written by the accelerator, sink FSM states and a sizing helper.
package pea_pkg;

  // Status codes carried in the status FIFO alongside each result word.
  typedef enum logic [1:0] {
    STATUS_OK        = 2'd0,
    STATUS_OVERFLOW  = 2'd1,
    STATUS_BAD_INSTR = 2'd2,
    STATUS_RSVD      = 2'd3
  } pea_status_e;

  // Result sink control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } sink_state_e;

  // Bits needed for a counter that must be able to hold the value 'limit'.
  function automatic int timer_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pea_sat_counter.sv
// Saturating up-counter with synchronous clear. Once it reaches all-ones it
// holds there until cleared or reset, so it never wraps back to zero.
module pea_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Clear wins over increment; increment stops at the maximum value.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != MAX_VAL)) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pea_result_sink.sv
// Consumer at the output end of the accelerator: pops one result word and one
// status word together, presents the pair on a valid/ready port, counts pairs
// and error statuses, and raises sticky done / desync flags.
module pea_result_sink
  import pea_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int STATUS_WIDTH   = 2,
  parameter int EXPECTED_COUNT = 0,
  parameter int DESYNC_TIMEOUT = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    result_empty,
  output logic                    result_r_en,
  input  logic [DATA_WIDTH-1:0]   result_data,
  input  logic                    status_empty,
  output logic                    status_r_en,
  input  logic [STATUS_WIDTH-1:0] status_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [STATUS_WIDTH-1:0] out_status,
  output logic [COUNT_WIDTH-1:0]  pair_count,
  output logic [COUNT_WIDTH-1:0]  error_count,
  output logic                    done,
  output logic                    desync
);

  localparam logic [STATUS_WIDTH-1:0] OK_CODE = STATUS_WIDTH'(STATUS_OK);

  // done can only fire when the target count fits in the counter.
  localparam bit DONE_ENABLED =
    (EXPECTED_COUNT > 0) &&
    (longint'(EXPECTED_COUNT) <= ((longint'(1) << COUNT_WIDTH) - 1));
  // Pair count value just before the FETCH that reaches the target.
  localparam logic [COUNT_WIDTH-1:0] DONE_PREV =
    COUNT_WIDTH'(DONE_ENABLED ? (EXPECTED_COUNT - 1) : 0);

  localparam int TIMER_WIDTH = timer_width(DESYNC_TIMEOUT);
  // Timer value before the one-sided cycle that makes it reach the timeout.
  localparam logic [TIMER_WIDTH-1:0] TIMER_PREV =
    TIMER_WIDTH'((DESYNC_TIMEOUT > 0) ? (DESYNC_TIMEOUT - 1) : 0);

  sink_state_e             state_reg;
  logic                    out_valid_reg;
  logic [DATA_WIDTH-1:0]   out_result_reg;
  logic [STATUS_WIDTH-1:0] out_status_reg;
  logic                    done_reg;
  logic                    desync_reg;

  logic                    can_pop;
  logic                    pop;
  logic                    fetch;
  logic                    status_err;
  logic                    one_sided;
  logic                    done_hit;
  logic                    desync_hit;
  logic [TIMER_WIDTH-1:0]  timer_count;

  assign can_pop    = !result_empty && !status_empty && !done_reg;
  assign fetch      = (state_reg == FETCH);
  assign status_err = (status_data != OK_CODE);
  assign one_sided  = result_empty ^ status_empty;
  assign done_hit   = DONE_ENABLED && fetch && (pair_count == DONE_PREV);
  assign desync_hit = one_sided && (timer_count >= TIMER_PREV);

  // Pop both FIFOs together; forced low while reset is held so nothing is
  // lost from the FIFOs during reset.
  always_comb begin
    pop = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE:    pop = can_pop;
        PRESENT: pop = out_valid_reg && out_ready && can_pop;
        default: pop = 1'b0;
      endcase
    end
  end

  assign result_r_en = pop;
  assign status_r_en = pop;

  pea_sat_counter #(.WIDTH(COUNT_WIDTH)) u_pair_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (fetch),
    .count (pair_count)
  );

  pea_sat_counter #(.WIDTH(COUNT_WIDTH)) u_error_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .inc   (fetch && status_err),
    .count (error_count)
  );

  // Counts consecutive cycles where only one FIFO has data.
  pea_sat_counter #(.WIDTH(TIMER_WIDTH)) u_desync_timer (
    .clock (clock),
    .reset (reset),
    .clr   (!one_sided),
    .inc   (one_sided),
    .count (timer_count)
  );

  // Sink FSM with registered output pair and sticky flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_status_reg <= '0;
      done_reg       <= 1'b0;
      desync_reg     <= 1'b0;
    end else begin
      if (desync_hit) begin
        desync_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          // FIFO read data is valid the cycle after the pop.
          out_result_reg <= result_data;
          out_status_reg <= status_data;
          out_valid_reg  <= 1'b1;
          if (done_hit) begin
            done_reg <= 1'b1;
          end
          state_reg <= PRESENT;
        end
        PRESENT: begin
          if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= pop ? FETCH : IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = out_result_reg;
  assign out_status = out_status_reg;
  assign done       = done_reg;
  assign desync     = desync_reg;

endmodule

// File: tb/tb_pea_result_sink.sv
// Bench for pea_result_sink: behavioural FIFOs feed two sink instances (one
// unbounded, one with EXPECTED_COUNT=2); a scoreboard queue holds the pairs
// expected to come out in order.
module tb_pea_result_sink;

  localparam int DW = 32;
  localparam int SW = 2;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic sel = 1'b0;
  logic out_ready = 1'b0;

  always #5 clock = ~clock;

  // Behavioural FIFOs: tasks write the memories and write pointers, the pop
  // process owns the read pointers and the registered read data.
  logic [DW-1:0] res_mem [0:63];
  logic [SW-1:0] sta_mem [0:63];
  int res_wr = 0, res_rd = 0, sta_wr = 0, sta_rd = 0;
  int ren_count = 0;
  logic result_empty, status_empty;
  logic [DW-1:0] result_data = '0;
  logic [SW-1:0] status_data = '0;

  assign result_empty = (res_wr == res_rd);
  assign status_empty = (sta_wr == sta_rd);

  logic a_result_r_en, a_status_r_en, a_out_valid, a_done, a_desync;
  logic [DW-1:0] a_out_result;
  logic [SW-1:0] a_out_status;
  logic [CW-1:0] a_pair_count, a_error_count;
  logic b_result_r_en, b_status_r_en, b_out_valid, b_done, b_desync;
  logic [DW-1:0] b_out_result;
  logic [SW-1:0] b_out_status;
  logic [CW-1:0] b_pair_count, b_error_count;

  pea_result_sink #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .EXPECTED_COUNT(0),
                    .DESYNC_TIMEOUT(16), .COUNT_WIDTH(CW)) dut_a (
    .clock(clock), .reset(reset),
    .result_empty(result_empty), .result_r_en(a_result_r_en), .result_data(result_data),
    .status_empty(status_empty), .status_r_en(a_status_r_en), .status_data(status_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_result(a_out_result), .out_status(a_out_status),
    .pair_count(a_pair_count), .error_count(a_error_count),
    .done(a_done), .desync(a_desync)
  );

  pea_result_sink #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .EXPECTED_COUNT(2),
                    .DESYNC_TIMEOUT(16), .COUNT_WIDTH(CW)) dut_b (
    .clock(clock), .reset(reset),
    .result_empty(result_empty), .result_r_en(b_result_r_en), .result_data(result_data),
    .status_empty(status_empty), .status_r_en(b_status_r_en), .status_data(status_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_out_result), .out_status(b_out_status),
    .pair_count(b_pair_count), .error_count(b_error_count),
    .done(b_done), .desync(b_desync)
  );

  // Selected instance drives the FIFOs and is the one observed.
  logic o_res_ren, o_sta_ren, o_valid, o_done, o_desync;
  logic [DW-1:0] o_result;
  logic [SW-1:0] o_status;
  logic [CW-1:0] o_pairs, o_errors;

  assign o_res_ren = sel ? b_result_r_en : a_result_r_en;
  assign o_sta_ren = sel ? b_status_r_en : a_status_r_en;
  assign o_valid   = sel ? b_out_valid   : a_out_valid;
  assign o_result  = sel ? b_out_result  : a_out_result;
  assign o_status  = sel ? b_out_status  : a_out_status;
  assign o_pairs   = sel ? b_pair_count  : a_pair_count;
  assign o_errors  = sel ? b_error_count : a_error_count;
  assign o_done    = sel ? b_done        : a_done;
  assign o_desync  = sel ? b_desync      : a_desync;

  always @(posedge clock) begin
    if (o_res_ren && (res_wr != res_rd)) begin
      result_data <= res_mem[res_rd[5:0]];
      res_rd      <= res_rd + 1;
    end
    if (o_sta_ren && (sta_wr != sta_rd)) begin
      status_data <= sta_mem[sta_rd[5:0]];
      sta_rd      <= sta_rd + 1;
    end
    if (o_res_ren) ren_count <= ren_count + 1;
  end

  logic [DW+SW-1:0] sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  task automatic push_result(input logic [DW-1:0] r);
    res_mem[res_wr[5:0]] = r;
    res_wr = res_wr + 1;
  endtask

  task automatic push_status(input logic [SW-1:0] s);
    sta_mem[sta_wr[5:0]] = s;
    sta_wr = sta_wr + 1;
  endtask

  task automatic push_pair(input logic [DW-1:0] r, input logic [SW-1:0] s);
    push_result(r);
    push_status(s);
    sb.push_back({s, r});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({o_valid, o_done, o_desync, o_res_ren} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid/done/desync/ren=%b, want 0000",
               {o_valid, o_done, o_desync, o_res_ren});
    end
    tests_run++;
    if ({o_pairs, o_errors, o_result, o_status} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got pairs=%0d errors=%0d result=%0d status=%0d, want all 0",
               o_pairs, o_errors, o_result, o_status);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int base, cyc;
    logic [DW+SW-1:0] e;
    logic seen;
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    base = ren_count;
    seen = 1'b0;
    @(negedge clock);
    push_pair(32'd5, 2'd0);
    #1;
    tests_run++;
    if (o_res_ren !== 1'b1 || o_sta_ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_first_pop: got r_en=%b/%b, want 1/1", o_res_ren, o_sta_ren);
    end
    for (cyc = 1; cyc <= 10 && !seen; cyc++) begin
      @(negedge clock);
      if (o_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        $display("[TB] single: pair result=%0d status=%0d at cycle %0d", o_result, o_status, cyc);
        tests_run++;
        if (cyc !== 2) begin
          tests_failed++;
          $display("FAIL single_latency: got %0d cycles, want 2", cyc);
        end
        tests_run++;
        if ({o_status, o_result} !== e) begin
          tests_failed++;
          $display("FAIL single_pair: got %0d/%0d, want %0d/%0d", o_result, o_status,
                   e[DW-1:0], e[DW+SW-1:DW]);
        end
        tests_run++;
        if (o_pairs !== 16'd1 || o_errors !== 16'd0) begin
          tests_failed++;
          $display("FAIL single_counts: got pairs=%0d errors=%0d, want 1/0", o_pairs, o_errors);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL single_timeout: got no out_valid in 10 cycles, want one pair");
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (ren_count - base !== 1) begin
      tests_failed++;
      $display("FAIL single_ren_pulses: got %0d, want 1", ren_count - base);
    end
  endtask

  task automatic test_stream();
    int got, last;
    logic [DW+SW-1:0] e;
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    got = 0;
    last = 0;
    @(negedge clock);
    push_pair(32'd10, 2'd0);
    push_pair(32'd20, 2'd1);
    push_pair(32'd30, 2'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (o_valid) begin
        $display("[TB] stream: pair result=%0d status=%0d at cycle %0d", o_result, o_status, c);
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL stream_extra: got unexpected pair %0d, want none", o_result);
        end else begin
          e = sb.pop_front();
          if ({o_status, o_result} !== e) begin
            tests_failed++;
            $display("FAIL stream_pair: got %0d/%0d, want %0d/%0d", o_result, o_status,
                     e[DW-1:0], e[DW+SW-1:DW]);
          end
        end
        if (got > 0) begin
          tests_run++;
          if (c - last !== 2) begin
            tests_failed++;
            $display("FAIL stream_spacing: got %0d cycles between pairs, want 2", c - last);
          end
        end
        last = c;
        got++;
      end
    end
    tests_run++;
    if (got !== 3 || o_pairs !== 16'd3 || o_errors !== 16'd1) begin
      tests_failed++;
      $display("FAIL stream_totals: got pairs_seen=%0d pair_count=%0d error_count=%0d, want 3/3/1",
               got, o_pairs, o_errors);
    end
  endtask

  task automatic test_back_pressure();
    int base;
    logic seen;
    logic [DW+SW-1:0] e;
    sel = 1'b0;
    do_reset();
    out_ready = 1'b0;
    base = ren_count;
    seen = 1'b0;
    @(negedge clock);
    push_pair(32'd10, 2'd0);
    push_pair(32'd20, 2'd0);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      seen = o_valid;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL bp_timeout: got no out_valid in 10 cycles, want one");
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests_run++;
      if (o_valid !== 1'b1 || o_result !== 32'd10 || ren_count - base !== 1) begin
        tests_failed++;
        $display("FAIL bp_stall: got valid=%b result=%0d pops=%0d, want 1/10/1",
                 o_valid, o_result, ren_count - base);
      end
    end
    out_ready = 1'b1;
    e = sb.pop_front();
    $display("[TB] back_pressure: pair result=%0d status=%0d", o_result, o_status);
    tests_run++;
    if ({o_status, o_result} !== e) begin
      tests_failed++;
      $display("FAIL bp_first: got %0d/%0d, want %0d/%0d", o_result, o_status,
               e[DW-1:0], e[DW+SW-1:DW]);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (o_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        $display("[TB] back_pressure: pair result=%0d status=%0d", o_result, o_status);
        tests_run++;
        if ({o_status, o_result} !== e) begin
          tests_failed++;
          $display("FAIL bp_second: got %0d/%0d, want %0d/%0d", o_result, o_status,
                   e[DW-1:0], e[DW+SW-1:DW]);
        end
      end
    end
    tests_run++;
    if (!seen || ren_count - base !== 2) begin
      tests_failed++;
      $display("FAIL bp_second_pop: got seen=%b pops=%0d, want 1/2", seen, ren_count - base);
    end
  endtask

  task automatic test_desync();
    int base;
    logic seen;
    logic [DW+SW-1:0] e;
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    base = ren_count;
    @(negedge clock);
    push_result(32'd99);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (i == 15) begin
        tests_run++;
        if (o_desync !== 1'b0) begin
          tests_failed++;
          $display("FAIL desync_early: got desync=%b after 15 cycles, want 0", o_desync);
        end
      end
    end
    tests_run++;
    if (o_desync !== 1'b1 || ren_count - base !== 0) begin
      tests_failed++;
      $display("FAIL desync_set: got desync=%b pops=%0d after 16 cycles, want 1/0",
               o_desync, ren_count - base);
    end
    push_status(2'd2);
    sb.push_back({2'd2, 32'd99});
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (o_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        $display("[TB] desync: pair result=%0d status=%0d", o_result, o_status);
        tests_run++;
        if ({o_status, o_result} !== e) begin
          tests_failed++;
          $display("FAIL desync_pair: got %0d/%0d, want %0d/%0d", o_result, o_status,
                   e[DW-1:0], e[DW+SW-1:DW]);
        end
      end
    end
    tests_run++;
    if (!seen || o_desync !== 1'b1 || o_errors !== 16'd1 || o_pairs !== 16'd1) begin
      tests_failed++;
      $display("FAIL desync_after: got seen=%b desync=%b errors=%0d pairs=%0d, want 1/1/1/1",
               seen, o_desync, o_errors, o_pairs);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic seen;
    logic [DW+SW-1:0] e;
    sel = 1'b0;
    do_reset();
    out_ready = 1'b1;
    @(negedge clock);
    push_pair(32'd7, 2'd1);
    push_pair(32'd8, 2'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({o_valid, o_res_ren, o_sta_ren} !== 3'b000 || o_pairs !== '0 || o_errors !== '0) begin
      tests_failed++;
      $display("FAIL midfetch_reset: got valid=%b ren=%b/%b pairs=%0d errors=%0d, want 0",
               o_valid, o_res_ren, o_sta_ren, o_pairs, o_errors);
    end
    void'(sb.pop_front());
    repeat (2) @(negedge clock);
    tests_run++;
    if (o_valid !== 1'b0 || o_pairs !== '0 || o_result !== '0) begin
      tests_failed++;
      $display("FAIL midfetch_held: got valid=%b pairs=%0d result=%0d, want 0/0/0",
               o_valid, o_pairs, o_result);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (o_res_ren !== 1'b1) begin
      tests_failed++;
      $display("FAIL midfetch_idle: got r_en=%b after release, want 1", o_res_ren);
    end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clock);
      if (o_valid) begin
        seen = 1'b1;
        e = sb.pop_front();
        $display("[TB] reset_mid_fetch: pair result=%0d status=%0d", o_result, o_status);
        tests_run++;
        if ({o_status, o_result} !== e || o_pairs !== 16'd1 || o_errors !== 16'd0) begin
          tests_failed++;
          $display("FAIL midfetch_pair: got %0d/%0d pairs=%0d errors=%0d, want %0d/%0d 1/0",
                   o_result, o_status, o_pairs, o_errors, e[DW-1:0], e[DW+SW-1:DW]);
        end
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL midfetch_timeout: got no pair after release, want one");
    end
  endtask

  task automatic test_done();
    int base, got;
    logic [DW+SW-1:0] e;
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    base = ren_count;
    got = 0;
    @(negedge clock);
    push_pair(32'd1, 2'd0);
    push_pair(32'd2, 2'd0);
    push_pair(32'd3, 2'd3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (o_valid) begin
        got++;
        $display("[TB] done: pair result=%0d status=%0d done=%b", o_result, o_status, o_done);
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL done_extra: got unexpected pair %0d, want none", o_result);
        end else begin
          e = sb.pop_front();
          if ({o_status, o_result} !== e || o_done !== (got == 2)) begin
            tests_failed++;
            $display("FAIL done_pair: got %0d/%0d done=%b, want %0d/%0d done=%b", o_result,
                     o_status, o_done, e[DW-1:0], e[DW+SW-1:DW], (got == 2));
          end
        end
      end
    end
    tests_run++;
    if (got !== 2 || o_done !== 1'b1 || o_pairs !== 16'd2 || ren_count - base !== 2) begin
      tests_failed++;
      $display("FAIL done_final: got pairs_seen=%0d done=%b pair_count=%0d pops=%0d, want 2/1/2/2",
               got, o_done, o_pairs, ren_count - base);
    end
    tests_run++;
    if (res_wr - res_rd !== 1 || sta_wr - sta_rd !== 1 || sb.size() !== 1) begin
      tests_failed++;
      $display("FAIL done_leftover: got fifo=%0d/%0d sb=%0d, want 1/1/1",
               res_wr - res_rd, sta_wr - sta_rd, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_desync();
    test_reset_mid_fetch();
    test_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
